// File: rtl/regfile_wb_pkg.sv
// Shared widths, request type and helpers for the register-file write-back arbiter.
package regfile_wb_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 64;
  localparam int MASK_W = DATA_W / 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } wb_req_t;

  function automatic logic bytes_overlap(input logic [MASK_W-1:0] mask_a,
                                         input logic [MASK_W-1:0] mask_b);
    return |(mask_a & mask_b);
  endfunction

endpackage

// File: rtl/regfile_wb_fifo.sv
// Single-lane write-back request FIFO with wrap-bit pointers; exposes per-slot
// valid flags and addresses so the top can build the pending-write bitmap.
module regfile_wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    push_i,
  input  wb_req_t                 push_req_i,
  input  logic                    pop_i,
  output logic                    full_o,
  output logic                    empty_o,
  output wb_req_t                 head_o,
  output logic [DEPTH-1:0]        ent_vld_o,
  output logic [DEPTH*ADDR_W-1:0] ent_addr_o
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_req_t        mem_q [DEPTH];
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0] count;
  logic           do_push, do_pop;

  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign count   = wr_ptr_q - rd_ptr_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // A slot is live when its distance from the read pointer is below the fill level.
  always_comb begin
    ent_vld_o  = '0;
    ent_addr_o = '0;
    for (int s = 0; s < DEPTH; s++) begin
      ent_vld_o[s] = {1'b0, PTR_W'(s) - rd_ptr_q[PTR_W-1:0]} < count;
      ent_addr_o[s*ADDR_W +: ADDR_W] = mem_q[s].addr;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_req_i;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back collection stage for the 8-write-port register file: per-lane FIFOs,
// byte-overlap conflict grant with starvation priority, registered W ports, pend bitmap.
// Optional WB_ARB_STATS_EN adds a saturating conflict_cnt output. Widths come from regfile_wb_pkg.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int LANES      = 8,
  parameter int DEPTH      = 4,
  parameter int STARVE_LIM = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [LANES-1:0]          wb_valid,
  output logic [LANES-1:0]          wb_ready,
  input  logic [LANES*ADDR_W-1:0]   wb_addr,
  input  logic [LANES*DATA_W-1:0]   wb_data,
  input  logic [LANES*MASK_W-1:0]   wb_mask,
  output logic [LANES-1:0]          w_en,
  output logic [LANES*ADDR_W-1:0]   w_addr,
  output logic [LANES*DATA_W-1:0]   w_data,
  output logic [LANES*MASK_W-1:0]   w_mask,
  output logic [2**ADDR_W-1:0]      pend
`ifdef WB_ARB_STATS_EN
  ,
  output logic [31:0]               conflict_cnt
`endif
);

  localparam int STALL_W = $clog2(STARVE_LIM + 1);

  wb_req_t                 push_req [LANES];
  wb_req_t                 head     [LANES];
  logic [DEPTH-1:0]        ent_vld  [LANES];
  logic [DEPTH*ADDR_W-1:0] ent_addr [LANES];
  logic [STALL_W-1:0]      stall_q  [LANES];
  logic [STALL_W-1:0]      stall_d  [LANES];

  logic [LANES-1:0]        push, full, empty, head_vld, grant, starve;
  logic [LANES-1:0]        w_en_q, w_en_d;
  logic [LANES*ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [LANES*DATA_W-1:0] w_data_q, w_data_d;
  logic [LANES*MASK_W-1:0] w_mask_q, w_mask_d;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign push_req[l].addr = wb_addr[l*ADDR_W +: ADDR_W];
    assign push_req[l].data = wb_data[l*DATA_W +: DATA_W];
    assign push_req[l].mask = wb_mask[l*MASK_W +: MASK_W];
    // Zero-mask requests are handshaken but never stored.
    assign push[l]     = wb_valid[l] && !full[l] && (push_req[l].mask != '0);
    assign wb_ready[l] = !full[l];
    assign head_vld[l] = !empty[l];

    regfile_wb_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .push_i     (push[l]),
      .push_req_i (push_req[l]),
      .pop_i      (grant[l]),
      .full_o     (full[l]),
      .empty_o    (empty[l]),
      .head_o     (head[l]),
      .ent_vld_o  (ent_vld[l]),
      .ent_addr_o (ent_addr[l])
    );
  end

  // A head loses to any overlapping valid head that starves while it does not,
  // or that has the same starvation status and a lower lane index.
  always_comb begin
    starve = '0;
    grant  = '0;
    for (int j = 0; j < LANES; j++) begin
      starve[j] = (stall_q[j] >= STALL_W'(STARVE_LIM));
    end
    for (int j = 0; j < LANES; j++) begin
      grant[j] = head_vld[j];
      for (int k = 0; k < LANES; k++) begin
        if (k != j && head_vld[k] &&
            head[k].addr == head[j].addr &&
            bytes_overlap(head[k].mask, head[j].mask) &&
            ((starve[k] && !starve[j]) || (starve[k] == starve[j] && k < j))) begin
          grant[j] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_en_d   = grant;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    w_mask_d = w_mask_q;
    for (int j = 0; j < LANES; j++) begin
      stall_d[j] = stall_q[j];
      if (grant[j] || !head_vld[j]) begin
        stall_d[j] = '0;
      end else if (!starve[j]) begin
        stall_d[j] = stall_q[j] + STALL_W'(1);
      end
      if (grant[j]) begin
        w_addr_d[j*ADDR_W +: ADDR_W] = head[j].addr;
        w_data_d[j*DATA_W +: DATA_W] = head[j].data;
        w_mask_d[j*MASK_W +: MASK_W] = head[j].mask;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      w_en_q   <= '0;
      w_addr_q <= '0;
      w_data_q <= '0;
      w_mask_q <= '0;
      for (int j = 0; j < LANES; j++) stall_q[j] <= '0;
    end else begin
      w_en_q   <= w_en_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      w_mask_q <= w_mask_d;
      for (int j = 0; j < LANES; j++) stall_q[j] <= stall_d[j];
    end
  end

  assign w_en   = w_en_q;
  assign w_addr = w_addr_q;
  assign w_data = w_data_q;
  assign w_mask = w_mask_q;

  // Scoreboard: anything still queued or sitting on a live W port is pending.
  always_comb begin
    pend = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int s = 0; s < DEPTH; s++) begin
        if (ent_vld[l][s]) pend[ent_addr[l][s*ADDR_W +: ADDR_W]] = 1'b1;
      end
      if (w_en_q[l]) pend[w_addr_q[l*ADDR_W +: ADDR_W]] = 1'b1;
    end
  end

`ifdef WB_ARB_STATS_EN
  logic [31:0] conflict_cnt_q, conflict_cnt_d;
  logic [32:0] cnt_sum;

  always_comb begin
    cnt_sum = {1'b0, conflict_cnt_q};
    for (int j = 0; j < LANES; j++) begin
      cnt_sum = cnt_sum + 33'(head_vld[j] && !grant[j]);
    end
    conflict_cnt_d = cnt_sum[32] ? '1 : cnt_sum[31:0];
  end

  always_ff @(posedge clock) begin
    if (reset) conflict_cnt_q <= '0;
    else       conflict_cnt_q <= conflict_cnt_d;
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus random traffic,
// all compared against a queue-based reference model.
module tb_regfile_wb_arbiter;
  import regfile_wb_pkg::*;

  localparam int LANES = 8;
  localparam int DEPTH = 4;
  localparam int LIM   = 4;

  logic                    clock = 1'b0;
  logic                    reset;
  logic [LANES-1:0]        wb_valid, wb_ready, w_en;
  logic [LANES*ADDR_W-1:0] wb_addr, w_addr;
  logic [LANES*DATA_W-1:0] wb_data, w_data;
  logic [LANES*MASK_W-1:0] wb_mask, w_mask;
  logic [2**ADDR_W-1:0]    pend;
`ifdef WB_ARB_STATS_EN
  logic [31:0]             conflict_cnt;
  longint                  m_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  regfile_wb_arbiter dut (
    .clock    (clock),
    .reset    (reset),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .wb_mask  (wb_mask),
    .w_en     (w_en),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .w_mask   (w_mask),
    .pend     (pend)
`ifdef WB_ARB_STATS_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [MASK_W-1:0] m;
  } mreq_t;

  mreq_t             q [LANES][$];
  int                stall [LANES];
  logic [LANES-1:0]  m_wen;
  logic [ADDR_W-1:0] m_waddr [LANES];
  logic [DATA_W-1:0] m_wdata [LANES];
  logic [MASK_W-1:0] m_wmask [LANES];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Lower rank wins; starving heads sit below every non-starving one.
  function automatic logic [LANES-1:0] model_grant();
    logic [LANES-1:0] g;
    int rank [LANES];
    g = '0;
    for (int l = 0; l < LANES; l++) rank[l] = (stall[l] >= LIM ? 0 : LANES) + l;
    for (int j = 0; j < LANES; j++) begin
      if (q[j].size() != 0) begin
        g[j] = 1'b1;
        for (int k = 0; k < LANES; k++) begin
          if (k != j && q[k].size() != 0 && q[k][0].a == q[j][0].a &&
              (q[k][0].m & q[j][0].m) != 0 && rank[k] < rank[j]) g[j] = 1'b0;
        end
      end
    end
    return g;
  endfunction

  task automatic model_edge();
    logic [LANES-1:0] g, acc;
    mreq_t r;
    if (reset) begin
      for (int l = 0; l < LANES; l++) begin
        q[l].delete();
        stall[l]   = 0;
        m_waddr[l] = '0;
        m_wdata[l] = '0;
        m_wmask[l] = '0;
      end
      m_wen = '0;
`ifdef WB_ARB_STATS_EN
      m_cnt = 0;
`endif
      return;
    end
    g = model_grant();
    for (int l = 0; l < LANES; l++) acc[l] = wb_valid[l] && (q[l].size() < DEPTH);
`ifdef WB_ARB_STATS_EN
    for (int l = 0; l < LANES; l++) if (q[l].size() != 0 && !g[l]) m_cnt++;
    if (m_cnt > 64'hFFFF_FFFF) m_cnt = 64'hFFFF_FFFF;
`endif
    for (int l = 0; l < LANES; l++) begin
      if (q[l].size() == 0 || g[l]) stall[l] = 0;
      else if (stall[l] < LIM) stall[l]++;
      m_wen[l] = g[l];
      if (g[l]) begin
        r = q[l].pop_front();
        m_waddr[l] = r.a;
        m_wdata[l] = r.d;
        m_wmask[l] = r.m;
      end
      if (acc[l] && wb_mask[l*MASK_W +: MASK_W] != 0) begin
        r.a = wb_addr[l*ADDR_W +: ADDR_W];
        r.d = wb_data[l*DATA_W +: DATA_W];
        r.m = wb_mask[l*MASK_W +: MASK_W];
        q[l].push_back(r);
      end
    end
  endtask

  task automatic compare_all();
    logic [LANES-1:0]        e_rdy;
    logic [LANES*ADDR_W-1:0] e_a;
    logic [LANES*DATA_W-1:0] e_d;
    logic [LANES*MASK_W-1:0] e_m;
    logic [2**ADDR_W-1:0]    e_p;
    e_p = '0;
    for (int l = 0; l < LANES; l++) begin
      e_rdy[l] = q[l].size() < DEPTH;
      e_a[l*ADDR_W +: ADDR_W] = m_waddr[l];
      e_d[l*DATA_W +: DATA_W] = m_wdata[l];
      e_m[l*MASK_W +: MASK_W] = m_wmask[l];
      for (int e = 0; e < q[l].size(); e++) e_p[q[l][e].a] = 1'b1;
      if (m_wen[l]) e_p[m_waddr[l]] = 1'b1;
    end
    chk("wb_ready", wb_ready, e_rdy);
    chk("w_en",     w_en,     m_wen);
    chk("w_addr",   w_addr,   e_a);
    chk("w_data",   w_data,   e_d);
    chk("w_mask",   w_mask,   e_m);
    chk("pend",     pend,     e_p);
`ifdef WB_ARB_STATS_EN
    chk("conflict_cnt", conflict_cnt, m_cnt[31:0]);
`endif
  endtask

  task automatic cyc();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    compare_all();
  endtask

  task automatic set_lane(input int l, input logic v, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
    wb_valid[l] = v;
    wb_addr[l*ADDR_W +: ADDR_W] = a;
    wb_data[l*DATA_W +: DATA_W] = d;
    wb_mask[l*MASK_W +: MASK_W] = m;
  endtask

  task automatic clear_inputs();
    wb_valid = '0;
    wb_addr  = '0;
    wb_data  = '0;
    wb_mask  = '0;
  endtask

  initial begin
    int pulses;
    int mr;
    logic [MASK_W-1:0] m;

    reset = 1'b1;
    clear_inputs();
    cyc();
    chk("rst_ready", wb_ready, 8'hFF);
    chk("rst_wen",   w_en,     8'h00);
    chk("rst_pend",  pend,     32'h0);
    cyc();
    reset = 1'b0;

    // Single write on lane 0.
    set_lane(0, 1'b1, 5'd5, 64'h1122334455667788, 8'hFF);
    cyc();
    clear_inputs();
    chk("single_pend_e1", pend[5], 1'b1);
    chk("single_wen_e1",  w_en,    8'h00);
    cyc();
    chk("single_wen_e2",  w_en,         8'h01);
    chk("single_addr_e2", w_addr[4:0],  5'd5);
    chk("single_data_e2", w_data[63:0], 64'h1122334455667788);
    chk("single_mask_e2", w_mask[7:0],  8'hFF);
    chk("single_pend_e2", pend[5],      1'b1);
    cyc();
    chk("single_wen_e3",  w_en,    8'h00);
    chk("single_pend_e3", pend[5], 1'b0);

    // Overlap conflict, lanes 1 and 3.
    set_lane(1, 1'b1, 5'd7, 64'hAAAA, 8'h0F);
    set_lane(3, 1'b1, 5'd7, 64'hBBBB, 8'h0F);
    cyc();
    clear_inputs();
    cyc();
    chk("conflict_first",  w_en, 8'h02);
    cyc();
    chk("conflict_second", w_en, 8'h08);
    cyc();

    // Disjoint masks on the same address issue together.
    set_lane(2, 1'b1, 5'd9, 64'hCCCC, 8'h0F);
    set_lane(4, 1'b1, 5'd9, 64'hDDDD, 8'hF0);
    cyc();
    clear_inputs();
    cyc();
    chk("disjoint_both", w_en, 8'h14);
    cyc();

    // Starvation: lane 6 waits behind a lane 0 stream.
    set_lane(0, 1'b1, 5'd3, 64'd1, 8'hFF);
    set_lane(6, 1'b1, 5'd3, 64'h66, 8'h01);
    cyc();
    set_lane(6, 1'b0, 5'd0, 64'd0, 8'h00);
    for (int i = 2; i <= 8; i++) begin
      set_lane(0, 1'b1, 5'd3, 64'(i), 8'hFF);
      cyc();
      if (i < 6)  chk("starve_wait", w_en[6], 1'b0);
      if (i == 6) begin
        chk("starve_grant6", w_en[6], 1'b1);
        chk("starve_stall0", w_en[0], 1'b0);
      end
    end
    clear_inputs();
    repeat (6) cyc();

    // Backpressure: lane 2 is held off by lane 1 until it starves.
    pulses = 0;
    for (int i = 1; i <= 6; i++) begin
      set_lane(1, 1'b1, 5'd10, 64'(100 + i), 8'hFF);
      set_lane(2, 1'b1, 5'd10, 64'(200 + i), 8'hFF);
      cyc();
      if (w_en[2]) pulses++;
      if (i == 4 || i == 5) chk("full_ready2", wb_ready[2], 1'b0);
    end
    clear_inputs();
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (w_en[2]) pulses++;
    end
    chk("full_issue_count", pulses, 4);

    // Zero-mask request is swallowed.
    set_lane(5, 1'b1, 5'd20, 64'h55, 8'h00);
    cyc();
    clear_inputs();
    chk("mask0_wen",  w_en[5],  1'b0);
    chk("mask0_pend", pend[20], 1'b0);
    cyc();
    chk("mask0_wen2", w_en[5],  1'b0);

    // Reset in the middle of traffic.
    for (int i = 0; i < 3; i++) begin
      for (int l = 0; l < LANES; l++)
        set_lane(l, 1'b1, ADDR_W'($urandom_range(0, 1)), {$urandom, $urandom}, 8'hFF);
      cyc();
    end
    reset = 1'b1;
    cyc();
    chk("midrst_wen",   w_en,     8'h00);
    chk("midrst_pend",  pend,     32'h0);
    chk("midrst_ready", wb_ready, 8'hFF);
    reset = 1'b0;
    clear_inputs();
    cyc();

    // Random traffic over a small address set to provoke conflicts.
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      for (int l = 0; l < LANES; l++) begin
        mr = $urandom_range(0, 5);
        case (mr)
          0:       m = 8'h00;
          1:       m = 8'hFF;
          2:       m = 8'h0F;
          3:       m = 8'hF0;
          4:       m = 8'h01;
          default: m = MASK_W'($urandom);
        endcase
        set_lane(l, $urandom_range(0, 9) < 6, ADDR_W'($urandom_range(0, 3)),
                 {$urandom, $urandom}, m);
      end
      cyc();
    end
    reset = 1'b0;
    clear_inputs();
    repeat (20) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
